// File: rtl/regfile_wb_if.sv
// regfile_wb_if: decode/writeback-side bundle for the register file.
//   ra1, ra2  : read indices                 (master -> slave)
//   rd1, rd2  : combinational read data      (slave -> master)
//   we, wa, wd: writeback enable/index/data  (master -> slave)
//   sb_set, sb_addr : mark a register pending (master -> slave)
//   busy1, busy2    : read index is pending and not written this cycle
//   pend_cnt        : registered count of pending registers
interface regfile_wb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic              busy1;
    logic              busy2;
    logic [ADDR_W:0]   pend_cnt;

    modport master (
        output ra1, ra2, we, wa, wd, sb_set, sb_addr,
        input  rd1, rd2, busy1, busy2, pend_cnt
    );

    modport slave (
        input  ra1, ra2, we, wa, wd, sb_set, sb_addr,
        output rd1, rd2, busy1, busy2, pend_cnt
    );
endinterface

// File: rtl/regfile_wb.sv
// regfile_wb: writeback-side MIPS register file with two combinational
// read ports, write-to-read bypass and a per-register pending scoreboard.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : regfile_wb_if.slave (read ports, writeback, scoreboard, status)
// Register 0 always reads 0 and is never written or marked pending.
module regfile_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_wb_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_sb;
    logic [ADDR_W:0]   r_pend_cnt;

    logic [DEPTH-1:0]  w_sb_next;
    logic [ADDR_W:0]   w_pend_cnt_next;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_busy1;
    logic              w_busy2;

    assign w_wr_en = bus.we && (bus.wa != '0);

    // Clear by writeback first, then set by issue: a same-cycle set wins.
    always_comb begin
        w_sb_next = r_sb;
        if (w_wr_en)
            w_sb_next[bus.wa] = 1'b0;
        if (bus.sb_set && (bus.sb_addr != '0))
            w_sb_next[bus.sb_addr] = 1'b1;
        w_sb_next[0] = 1'b0;
    end

    always_comb begin
        w_pend_cnt_next = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            w_pend_cnt_next = w_pend_cnt_next + {{ADDR_W{1'b0}}, w_sb_next[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[bus.wa] <= bus.wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb       <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_sb       <= w_sb_next;
            r_pend_cnt <= w_pend_cnt_next;
        end
    end

    // Reads bypass the in-flight writeback; a bypassed read is never busy.
    always_comb begin
        w_rd1 = '0;
        if (bus.ra1 != '0) begin
            if (bus.we && (bus.wa == bus.ra1))
                w_rd1 = bus.wd;
            else
                w_rd1 = r_mem[bus.ra1];
        end
    end

    always_comb begin
        w_rd2 = '0;
        if (bus.ra2 != '0) begin
            if (bus.we && (bus.wa == bus.ra2))
                w_rd2 = bus.wd;
            else
                w_rd2 = r_mem[bus.ra2];
        end
    end

    assign w_busy1 = (bus.ra1 != '0) && r_sb[bus.ra1] && !(bus.we && (bus.wa == bus.ra1));
    assign w_busy2 = (bus.ra2 != '0) && r_sb[bus.ra2] && !(bus.we && (bus.wa == bus.ra2));

    assign bus.rd1      = w_rd1;
    assign bus.rd2      = w_rd2;
    assign bus.busy1    = w_busy1;
    assign bus.busy2    = w_busy2;
    assign bus.pend_cnt = r_pend_cnt;
endmodule

// File: doc/regfile_wb.md
# regfile_wb

Writeback-side register file for the single-issue MIPS datapath: it consumes the 5-bit destination register index chosen in decode (rt or rd) together with the writeback data, and decodes that index into one of 31 writable 32-bit registers. Two combinational read ports serve decode, and same-cycle writeback-to-read bypass is built in. A per-register pending scoreboard lets decode stall on registers owned by an in-flight multi-cycle producer (load, mult/div).

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width; depth is 2**ADDR_W

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- ra1  input  ADDR_W  read port 1 index
- ra2  input  ADDR_W  read port 2 index
- rd1  output  DATA_W  read port 1 data, combinational
- rd2  output  DATA_W  read port 2 data, combinational
- we  input  1  write enable
- wa  input  ADDR_W  write index, the selected destination register
- wd  input  DATA_W  write data
- sb_set  input  1  mark register sb_addr pending; asserted by issue of a multi-cycle producer
- sb_addr  input  ADDR_W  register to mark pending
- busy1  output  1  ra1 is pending, and its value is not being written this cycle
- busy2  output  1  ra2 is pending, and its value is not being written this cycle
- pend_cnt  output  ADDR_W+1  registered count of pending registers

## Operation
- Storage: registers 1..31, each DATA_W bits. Register 0 has no storage and always reads 0.
- Write: on a rising clk edge with we=1 and wa!=0, reg[wa] <= wd. A write to wa=0 is discarded.
- Read, for each port n: if ran=0, rdn=0. Otherwise, if we=1 and wa=ran, rdn=wd (bypass). Otherwise, rdn=reg[ran].
- Scoreboard: one pending bit per register 1..31, sb[0] is constant 0. The next-state value is computed in this order:
  1. A write with we=1 and wa!=0 clears sb[wa].
  2. sb_set=1 with sb_addr!=0 sets sb[sb_addr].
  - If both target the same register in the same cycle, set wins and the bit ends at 1 (a new producer has taken ownership).
  - sb_set on an already-pending register leaves it at 1. There is no double-counting.
  - sb_set with sb_addr=0 is ignored.
- busyn = sb[ran] & ~(we & (wa==ran)). It is forced to 0 when ran=0. A same-cycle writeback resolves the hazard through the bypass.
- pend_cnt: registered popcount of the next-state scoreboard, so it always equals the popcount of sb as held after each edge.
- Reads have no side effects. Both read ports may address the same register.

## Timing
- Reset (rst_n=0, asynchronous): all registers 0, all sb bits 0, pend_cnt=0. While reset is held, rd1/rd2 return 0 for every index (except through bypass), busy1=busy2=0, and writes and sets are ignored. Release of reset is sampled on the next rising edge.
- Reset asserted mid-operation discards all pending state immediately, without waiting for a clock edge.
- Write latency: the value written at edge k is readable from storage after edge k. During cycle k it is visible only through the bypass.
- sb_set at edge k: busy is visible from after edge k. pend_cnt updates at the same edge.
- The write clear at edge k makes sb[wa]=0 after edge k. Before that edge, busy is already 0 because of the bypass term.
- All outputs except pend_cnt are combinational from ra*, we, wa, wd and the stored state. There is no clock-to-out latency on the read ports.

## Test plan
- Reset check: after reset, with ra1=5 and ra2=31, require rd1=rd2=0, busy1=busy2=0 and pend_cnt=0. Then write 0xDEADBEEF to reg 5; while rst_n is still held, require rd1=0.
- R0 protection: write we=1, wa=0, wd=0xFFFFFFFF, then ra1=0; require rd1=0. sb_set with sb_addr=0 leaves pend_cnt=0.
- Bypass: in one cycle drive we=1, wa=7, wd=0x12345678 and ra1=ra2=7; require rd1=rd2=0x12345678 in that same cycle. After the edge, with we=0, the value still reads back as 0x12345678.
- Scoreboard: sb_set reg 8 at edge 1 gives busy1=1 for ra1=8 and pend_cnt=1. A write to reg 8 with wd=0xA5 in cycle 3 gives busy1=0 and rd1=0xA5 in that cycle; after the edge, pend_cnt=0.
- Simultaneous set and clear: sb_set reg 9 at edge 1. At edge 2 drive we=1, wa=9, sb_set=1, sb_addr=9; require sb[9] remains 1 and pend_cnt=1 afterwards. Then sb_set regs 1..31 in sequence; require pend_cnt=31, and a repeated set of reg 3 keeps it at 31.
- Async reset mid-operation: with pend_cnt=4 and reg 10=0x55, pull rst_n low between clock edges; require pend_cnt=0 and rd for ra=10 equal to 0 immediately, with no clock edge needed.
